// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - blocking-miss line writeback/refill controller
`ifndef CACHE_T
`define CACHE_T 20
`endif
`ifndef CACHE_S
`define CACHE_S 8
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_refill_ctrl #(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int SET_WIDTH    = `CACHE_S,
    parameter int OFFSET_WIDTH = `CACHE_B
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [31:0]             req_addr,
    input  logic                    hit,
    input  logic                    dirty,
    input  logic [TAG_WIDTH-1:0]    replace_tag,
    input  logic [31:0]             line_rdata,
    output logic                    req_ready,
    output logic                    lru_en,
    output logic [OFFSET_WIDTH-3:0] word_idx,
    output logic                    fill_wen,
    output logic [31:0]             fill_data,
    output logic                    tag_wen,
    output logic                    mem_req,
    output logic                    mem_wen,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ready,
    input  logic [31:0]             mem_rdata
);
    localparam int IDX_W = OFFSET_WIDTH - 2;
    localparam logic [IDX_W-1:0] LAST_WORD = {IDX_W{1'b1}};

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] REFILL    = 2'd2;
    localparam logic [1:0] COMMIT    = 2'd3;

    logic [1:0]           state;
    logic [IDX_W-1:0]     word_cnt;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [TAG_WIDTH-1:0] victim_tag_q;
    logic [SET_WIDTH-1:0] set_q;

    // Byte offset is irrelevant: whole lines move.
    logic unused_offset;
    assign unused_offset = &{1'b0, req_addr[OFFSET_WIDTH-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            tag_q        <= '0;
            victim_tag_q <= '0;
            set_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !hit) begin
                        tag_q        <= req_addr[OFFSET_WIDTH+SET_WIDTH +: TAG_WIDTH];
                        set_q        <= req_addr[OFFSET_WIDTH +: SET_WIDTH];
                        victim_tag_q <= replace_tag;
                        word_cnt     <= '0;
                        state        <= dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= REFILL;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= COMMIT;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so asserting it silences everything at once.
    always_comb begin
        req_ready = 1'b0;
        lru_en    = 1'b0;
        fill_wen  = 1'b0;
        fill_data = '0;
        tag_wen   = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    req_ready = req_valid && hit;
                    lru_en    = req_valid && hit;
                end
                WRITEBACK: begin
                    mem_req   = 1'b1;
                    mem_wen   = 1'b1;
                    mem_addr  = {victim_tag_q, set_q, word_cnt, 2'b00};
                    mem_wdata = line_rdata;
                end
                REFILL: begin
                    mem_req   = 1'b1;
                    mem_addr  = {tag_q, set_q, word_cnt, 2'b00};
                    fill_wen  = mem_ready;
                    fill_data = mem_rdata;
                end
                default: tag_wen = 1'b1;
            endcase
        end
    end

    assign word_idx = reset ? word_cnt : '0;
endmodule
